csa_mult_sequencer: RTL and testbench
=====================================

# csa_mult_sequencer

Iterative unsigned multiplier controller that time-shares one 2·WIDTH-bit carry-save adder row and one 2·WIDTH-bit carry-propagate adder to compute A×B. It reduces one partial product per cycle into redundant sum/carry registers, then resolves the result once through the carry-propagate adder. It is the area-lean sequential counterpart to the full Wallace-tree array and sits behind a valid/ready operand interface, with a valid/ready result interface.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2; the product is 2·WIDTH bits
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands A, B are valid this cycle
- in_ready  output  1  block can accept operands; high only in IDLE
- A  input  WIDTH  multiplicand, unsigned
- B  input  WIDTH  multiplier, unsigned
- out_valid  output  1  P holds a completed product
- out_ready  input  1  consumer accepts P
- P  output  2·WIDTH  product A×B
- busy  output  1  high in REDUCE or RESOLVE

## Operation
- Datapath: one carry_save_adder (WIDTH = 2·WIDTH) and one carry_propagate_adder (WIDTH = 2·WIDTH; its top sum bit is discarded).
- Registers:
  - a_q, b_q (operands)
  - SUM, CARRY (2·WIDTH each)
  - cnt (clog2(WIDTH) bits)
  - state
  - P
- States: IDLE, REDUCE, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A→a_q and B→b_q; clear SUM, CARRY and cnt to 0; go to REDUCE.
- REDUCE:
  - Partial product: pp = b_q[cnt] ? (a_q zero-extended to 2·WIDTH) << cnt : 0.
  - CSA inputs: X=SUM, Y=(CARRY<<1) truncated to 2·WIDTH, Z=pp.
  - Register updates: SUM←CSA.S, CARRY←CSA.C.
  - cnt increments each cycle.
  - When cnt==WIDTH-1 (the last partial product is consumed this cycle), go to RESOLVE.
- RESOLVE:
  - P←(SUM + (CARRY<<1)) mod 2^(2·WIDTH), computed through the CPA.
  - Go to DONE.
- DONE:
  - out_valid=1; P is held stable.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic: all reduction is modulo 2^(2·WIDTH). Carries shifted out of bit 2·WIDTH-1 are dropped. The result is exact because A×B < 2^(2·WIDTH).
- Operand isolation: in_valid is ignored outside IDLE. Changes on A and B after acceptance have no effect.
- Reset (asynchronous, at any time including mid-REDUCE): state=IDLE, P=0, SUM=0, CARRY=0, cnt=0, a_q=0, b_q=0, out_valid=0, busy=0. in_ready=1 while rst_n is deasserted-high in IDLE. Any in-flight operation is discarded with no output.

## Timing
- Output values:
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state==REDUCE || state==RESOLVE)
  - All are decoded from registered state; there are no combinational paths from inputs to outputs.
- Latency:
  - Operand handshake at edge e0.
  - REDUCE occupies edges e1..eWIDTH.
  - RESOLVE completes at edge eWIDTH+1, so out_valid is high from cycle WIDTH+1 after acceptance (9 cycles for WIDTH=8).
- Result handshake:
  - out_valid stays high and P stays constant until the out_ready handshake.
  - out_valid deasserts and in_ready asserts on the next cycle.
  - A new operand pair can be accepted no earlier than one cycle after the result handshake.
  - Minimum initiation interval is WIDTH+3 cycles with out_ready tied high.
- P retains its value after leaving DONE and is only overwritten in RESOLVE.

## Test plan
- WIDTH=8, reset, then A=0x0D, B=0x0B, out_ready=1 -> out_valid rises 9 cycles after acceptance with P=0x008F; in_ready returns high 1 cycle after the result handshake.
- Corner operands:
  - A=0xFF, B=0xFF -> P=0xFE01.
  - A=0x00, B=0xFF -> P=0x0000.
  - A=0x80, B=0x80 -> P=0x4000.
- Back-pressure: A=0x12, B=0x34, out_ready low 5 cycles after out_valid -> P=0x03A8 stable throughout; in_valid pulses with other operands during busy/DONE are ignored; the next accepted pair computes correctly.
- Reset mid-operation: assert rst_n=0 at REDUCE cnt=3 -> outputs reset immediately (P=0, out_valid=0, busy=0); after release, A=0x07, B=0x06 -> P=0x002A.
- Randomized: 1000 random operand pairs with random in_valid/out_ready gaps, for WIDTH=2, 4, 8, 16 -> every P equals A×B, with exactly one result per accepted pair, in order.

Source files
------------

// File: rtl/csa_mult_sequencer.sv
// Sequential unsigned multiplier: one CSA row reduces a partial
// product per cycle, one CPA resolves the redundant result once.

module carry_save_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module carry_propagate_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s
);
  assign s = {1'b0, a} + {1'b0, b};
endmodule

module csa_mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE, REDUCE, RESOLVE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    sum_q, carry_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    p_q;

  logic [PW-1:0] pp, carry_sh;
  logic [PW-1:0] csa_s, csa_c;
  logic [PW:0]   cpa_sum;
  logic          unused_cpa_top;

  assign carry_sh = carry_q << 1;
  assign pp = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;

  carry_save_adder #(.WIDTH(PW)) u_csa (
    .x (sum_q),
    .y (carry_sh),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  carry_propagate_adder #(.WIDTH(PW)) u_cpa (
    .a (sum_q),
    .b (carry_sh),
    .s (cpa_sum)
  );

  // Product fits in PW bits, so the adder carry-out is never needed
  assign unused_cpa_top = cpa_sum[PW];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)       state_d = REDUCE;
      REDUCE:  if (cnt == LAST)    state_d = RESOLVE;
      RESOLVE:                     state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Operand capture, reduction and final resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt     <= '0;
      p_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= A;
          b_q     <= B;
          sum_q   <= '0;
          carry_q <= '0;
          cnt     <= '0;
        end
        REDUCE: begin
          sum_q   <= csa_s;
          carry_q <= csa_c;
          cnt     <= cnt + CW'(1);
        end
        RESOLVE: p_q <= cpa_sum[PW-1:0];
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == REDUCE) || (state_q == RESOLVE);
  assign P         = p_q;

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer: directed corners, back-pressure,
// mid-operation reset and a randomized scoreboard run.

module tb_csa_mult_sequencer;
  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int N  = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [PW-1:0] p;

  int checks = 0;
  int failures = 0;

  csa_mult_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return PW'(r);
  endfunction

  task automatic run_op(input logic [W-1:0] ai,
                        input logic [W-1:0] bi,
                        input int hold,
                        input bit noise);
    int n;
    logic [PW-1:0] exp;
    exp = ref_mul(ai, bi);
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    in_valid = 1'b1;
    a = ai;
    b = bi;
    step();
    in_valid = 1'b0;
    if (noise) begin
      a = ~ai;
      b = ~bi;
    end
    check("busy_after_accept", 32'(busy), 1);
    n = 0;
    while (!out_valid && n < 40) begin
      if (noise) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      n++;
    end
    check("latency", n, 9);
    check("product", 32'(p), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_p", 32'(p), 32'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 0);
    check("post_hs_ready", 32'(in_ready), 1);
    check("p_retained", 32'(p), 32'(exp));
  endtask

  initial begin
    int acc, got, cyc;
    bit hold_v;
    logic [PW-1:0] held;
    logic [PW-1:0] q[$];

    step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_p", 32'(p), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op(8'h0D, 8'h0B, 0, 1'b0);
    check("p_0d_0b", 32'(p), 32'h008F);
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    check("p_ff_ff", 32'(p), 32'hFE01);
    run_op(8'h00, 8'hFF, 0, 1'b0);
    check("p_00_ff", 32'(p), 32'h0000);
    run_op(8'h80, 8'h80, 0, 1'b0);
    check("p_80_80", 32'(p), 32'h4000);
    run_op(8'h12, 8'h34, 5, 1'b1);
    check("p_12_34", 32'(p), 32'h03A8);
    run_op(8'h21, 8'h43, 0, 1'b0);

    // reset in the middle of reduction
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h33;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_p", 32'(p), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("after_rst_valid", 32'(out_valid), 0);
    run_op(8'h07, 8'h06, 0, 1'b0);
    check("p_07_06", 32'(p), 32'h002A);

    // randomized traffic against a queue of expected products
    acc = 0;
    got = 0;
    cyc = 0;
    hold_v = 1'b0;
    held = '0;
    while ((acc < N || q.size() != 0) && cyc < 60000) begin
      in_valid  = (acc < N) && ($urandom_range(0, 2) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      #0;
      check("rand_onehot", 32'(in_ready) + 32'(out_valid) + 32'(busy), 1);
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(a, b));
        acc++;
      end
      if (out_valid && hold_v)
        check("rand_hold", 32'(p), 32'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0)
          check("rand_extra_result", 1, 0);
        else
          check("rand_p", 32'(p), 32'(q.pop_front()));
        got++;
        hold_v = 1'b0;
      end else if (out_valid) begin
        held = p;
        hold_v = 1'b1;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_timeout", 32'(cyc < 60000), 1);
    check("rand_count", got, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
